// File: rtl/riscv_hazard_pkg.sv
// Shared types, select codes and tag helpers for the hazard/forwarding controller.
package riscv_hazard_pkg;

    // Operand source codes for the EX-stage forward muxes (2'b11 is never produced).
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    // Number of source operands per instruction (rs1, rs2).
    localparam int NUM_SRC = 2;

    // Destination-register tag that follows an instruction down EX -> MEM -> WB.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } hazard_tag_t;

    localparam hazard_tag_t TAG_INVALID = '0;

    // A tag produces source rs when it is a live register write to rs; x0 never matches.
    function automatic logic tag_match(hazard_tag_t tag, logic [4:0] rs);
        return tag.valid && tag.reg_write && (tag.rd == rs) && (rs != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand match and forward-select logic; purely combinational.
module hazard_fwd_sel
    import riscv_hazard_pkg::*;
(
    input  hazard_tag_t ex_tag,
    input  hazard_tag_t mem_tag,
    input  logic        src_valid,
    input  logic [4:0]  rs,
    input  logic        kill,
    output logic        ex_load_hit,
    output logic [1:0]  sel
);

    logic ex_hit;
    logic mem_hit;

    // Only a real instruction that actually reads this source can hit a producer.
    assign ex_hit  = src_valid && tag_match(ex_tag, rs);
    assign mem_hit = src_valid && tag_match(mem_tag, rs);

    // A load in EX cannot forward its data in time; the top turns this into a stall.
    assign ex_load_hit = ex_hit && ex_tag.mem_read;

    // Newest producer wins; a bubble or flush entering EX reads the regfile path.
    always_comb begin
        sel = FWD_REGFILE;
        if (!kill) begin
            if (ex_hit) begin
                sel = FWD_EXMEM;
            end else if (mem_hit) begin
                sel = FWD_MEMWB;
            end
        end
    end

    // Whether the MEM-stage instruction is a load does not change its select.
    logic unused_mem_read;
    assign unused_mem_read = mem_tag.mem_read;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: tag pipeline, forward selects, load-use stall,
// branch flush and saturating stall/flush event counters.
module hazard_forward_ctrl
    import riscv_hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idValid,
    input  logic [4:0]       idRs1,
    input  logic [4:0]       idRs2,
    input  logic             idUsesRs1,
    input  logic             idUsesRs2,
    input  logic [4:0]       idRd,
    input  logic             idRegWrite,
    input  logic             idMemRead,
    input  logic             branchTaken,
    output logic [1:0]       forwardSelect1,
    output logic [1:0]       forwardSelect2,
    output logic             stallPc,
    output logic             stallIfId,
    output logic             bubbleIdEx,
    output logic             flushIfId,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Tag pipeline: EX, MEM, WB.
    hazard_tag_t ex_tag_q;
    hazard_tag_t ex_tag_d;
    hazard_tag_t mem_tag_q;
    hazard_tag_t wb_tag_q;

    // Per-operand views of the ID instruction.
    logic [4:0]              src_rs [NUM_SRC];
    logic [NUM_SRC-1:0]      src_used;
    logic [NUM_SRC-1:0]      src_ex_load_hit;
    logic [NUM_SRC-1:0][1:0] sel_d;
    logic [NUM_SRC-1:0][1:0] sel_q;

    // Hazard decisions for this cycle.
    logic load_use;
    logic stall;
    logic bubble;

    // Event counters.
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;
    logic [CNT_W-1:0] flush_count_q;
    logic [CNT_W-1:0] flush_count_d;

    assign src_rs[0]   = idRs1;
    assign src_rs[1]   = idRs2;
    assign src_used[0] = idUsesRs1;
    assign src_used[1] = idUsesRs2;

    // One select/match slice per source operand.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            hazard_fwd_sel u_fwd_sel (
                .ex_tag      (ex_tag_q),
                .mem_tag     (mem_tag_q),
                .src_valid   (idValid & src_used[gi]),
                .rs          (src_rs[gi]),
                .kill        (bubble),
                .ex_load_hit (src_ex_load_hit[gi]),
                .sel         (sel_d[gi])
            );
        end
    endgenerate

    // Load-use stalls unless a taken branch discards the ID instruction anyway.
    always_comb begin
        load_use = |src_ex_load_hit;
        stall    = load_use && !branchTaken;
        bubble   = load_use || branchTaken;
    end

    // Next EX tag: a bubble or flush enters EX as an invalid entry.
    always_comb begin
        ex_tag_d = TAG_INVALID;
        if (!bubble) begin
            ex_tag_d.valid     = idValid;
            ex_tag_d.rd        = idRd;
            ex_tag_d.reg_write = idRegWrite;
            ex_tag_d.mem_read  = idMemRead;
        end
    end

    // Saturating per-cycle event counters.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (load_use && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (branchTaken && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // All controller state; the tag pipeline advances every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_tag_q      <= TAG_INVALID;
            mem_tag_q     <= TAG_INVALID;
            wb_tag_q      <= TAG_INVALID;
            sel_q         <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            ex_tag_q      <= ex_tag_d;
            mem_tag_q     <= ex_tag_q;
            wb_tag_q      <= mem_tag_q;
            sel_q         <= sel_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // The WB producer is covered by the write-before-read register file, so its tag
    // is tracked but never feeds a select.
    logic unused_wb_tag;
    assign unused_wb_tag = ^wb_tag_q;

    assign forwardSelect1 = sel_q[0];
    assign forwardSelect2 = sel_q[1];
    assign stallPc        = stall;
    assign stallIfId      = stall;
    assign bubbleIdEx     = bubble;
    assign flushIfId      = branchTaken;
    assign stallCount     = stall_count_q;
    assign flushCount     = flush_count_q;

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Hazard and forwarding controller for the 5-stage pipeline. It tracks destination-register tags for instructions in EX, MEM and WB. During ID it decides the operand source for each EX-stage forward mux, registers the 2-bit select codes so they are stable for the whole EX cycle, detects load-use hazards and inserts bubbles, and squashes wrong-path instructions on a taken branch. It also keeps saturating stall/flush event counters for performance debug.

## Interface
Parameters:
- CNT_W, 16: width of stall/flush event counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- idValid  in  1  ID stage holds a real (non-bubble) instruction.
- idRs1, idRs2  in  5 each  source register indices of the instruction in ID.
- idUsesRs1, idUsesRs2  in  1 each  instruction actually reads that source.
- idRd  in  5  destination register of the instruction in ID.
- idRegWrite  in  1  instruction in ID writes idRd.
- idMemRead  in  1  instruction in ID is a load.
- branchTaken  in  1  EX resolved a taken branch/jump this cycle.
- forwardSelect1, forwardSelect2  out  2 each  registered selects for EX operand muxes: 00 regfile, 01 EX/MEM result, 10 MEM/WB result; 11 never driven.
- stallPc  out  1  hold PC this cycle.
- stallIfId  out  1  hold IF/ID register this cycle.
- bubbleIdEx  out  1  load NOP into ID/EX this cycle.
- flushIfId  out  1  squash IF/ID this cycle.
- stallCount, flushCount  out  CNT_W each  saturating event counters.

## Operation
- The internal tag pipeline exTag → memTag → wbTag holds {valid, rd, regWrite, memRead} per entry and advances every cycle; there is no global pipeline freeze.
- A tag "matches" source r when valid & regWrite & rd == r & r != 0. x0 never forwards and never stalls.
- Load-use hazard: loadUse = idValid & exTag.valid & exTag.memRead & match on any used rs.
- Select computation per operand, written into forwardSelectN at the edge:
  - If a bubble or flush enters EX: 00.
  - Else if exTag matches: 01. exTag is in MEM next cycle; newest producer wins.
  - Else if memTag matches: 10.
  - Else: 00.
- wbTag is kept only so MEM/WB-to-ID writes are covered. The register file is write-before-read, so no select is generated for wbTag.
- Combinational control outputs:
  - stallPc = stallIfId = loadUse & !branchTaken.
  - bubbleIdEx = loadUse | branchTaken.
  - flushIfId = branchTaken.
- Next exTag: if bubbleIdEx then invalid, else {idValid, idRd, idRegWrite, idMemRead}.
- Flush has priority over stall. On a simultaneous flush and stall, the stall is suppressed and the ID instruction is discarded.
- Counters increment by 1 per cycle of loadUse (stallCount) or branchTaken (flushCount) and saturate at all-ones.

## Timing
- Reset (synchronous): all tags invalid, forwardSelect1/2 = 00, counters = 0. With tags invalid, stallPc, stallIfId, bubbleIdEx and flushIfId evaluate to 0 unless branchTaken = 1.
- forwardSelect latency: one cycle. It is computed in ID and valid for the whole EX cycle of the same instruction.
- A load-use hazard costs exactly one stall cycle. In the following cycle the load is in MEM (memTag) and the held consumer gets select 10.
- Back-to-back loads with dependent consumers stall one cycle each. A stall never lasts two cycles for the same hazard.
- A reset asserted mid-stall or mid-flush clears all state in that cycle. Outputs come out of reset as above.

## Structure
- Shared package riscv_hazard_pkg holds:
  - Constants FWD_REGFILE = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - The tag typedef {valid, rd[4:0], regWrite, memRead}.
  - Function tag_match(tag, rs).
- One sub-module, hazard_fwd_sel: purely combinational select and match logic for one operand, instantiated twice.
- Tag registers, stall/flush logic and counters live in the top module.

## Test plan
- Reset: assert reset 2 cycles with idValid = 1 and random inputs → selects 00, stall and bubble 0, counters 0.
- EX forward: add x5 (ID), then next cycle sub x6,x5,x1 in ID → the cycle the sub is in EX, forwardSelect1 = 01, forwardSelect2 = 00, no stall.
- MEM forward and priority:
  - add x5, nop, then use x5 → forwardSelect1 = 10.
  - add x5, add x5, then use x5 → forwardSelect1 = 01 (newest wins).
- Load-use: lw x7, then add x8,x7,x7 → one cycle stallPc = stallIfId = bubbleIdEx = 1, stallCount = 1. Next cycle both selects = 10.
- x0 and unused sources:
  - addi x0 followed by a read of x0 → selects 00.
  - lw x7 followed by an instruction with idUsesRs1 = 0 and rs1 = 7 → no stall.
- Flush over stall: lw x7 in EX, dependent in ID, and branchTaken = 1 in the same cycle → flushIfId = 1, bubbleIdEx = 1, stallPc = 0, flushCount = 1, stallCount = 1. Next-cycle exTag invalid, selects 00.
